// File: rtl/duc_iq_dac_packer.sv
// Pairs registered I/Q samples into {Q,I} DAC words, buffers them in a small FIFO
// behind a handshaked output register, and tracks pairing/overflow errors.
module duc_iq_dac_packer #(
   parameter int DW    = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_enable,
   input  logic            i_data_vld,
   input  logic            i_data_ca,
   input  logic [DW-1:0]   i_data,
   output logic [2*DW-1:0] o_dac_data,
   output logic            o_dac_vld,
   input  logic            i_dac_rdy,
   output logic [AW:0]     o_fifo_level,
   output logic            o_ovf_sticky,
   output logic            o_pair_err_sticky,
   input  logic            i_clr_err,
   output logic [15:0]     o_err_cnt
);

   typedef enum logic {WAIT_I, WAIT_Q} pairState_t;

   pairState_t          state_q;
   logic                vld_q;
   logic                ca_q;
   logic [DW-1:0]       data_q;
   logic [DW-1:0]       iLatch_q;
   logic [AW-1:0]       wrPtr_q;
   logic [AW-1:0]       rdPtr_q;
   logic [AW:0]         level_q;
   logic [AW:0]         level_d;
   logic                outVld_q;
   logic [2*DW-1:0]     outData_q;
   logic                ovfSticky_q;
   logic                pairSticky_q;
   logic [15:0]         errCnt_q;
   logic [15:0]         errCnt_d;
   logic [16:0]         errSum;
   logic [2*DW-1:0]     mem [DEPTH];

   logic sampleEvt;
   logic wrEn;
   logic pairErr;
   logic fifoFull;
   logic fifoEmpty;
   logic pop;
   logic ovf;
   logic push;

   // A full FIFO still accepts a write when the head is leaving on the same edge.
   always_comb begin
      sampleEvt = i_enable & vld_q;
      wrEn      = sampleEvt & (state_q == WAIT_Q) & ca_q;
      pairErr   = sampleEvt & (((state_q == WAIT_I) & ca_q) | ((state_q == WAIT_Q) & ~ca_q));
      fifoFull  = (level_q == (AW+1)'(DEPTH));
      fifoEmpty = (level_q == '0);
      pop       = ~fifoEmpty & (~outVld_q | i_dac_rdy);
      ovf       = wrEn & fifoFull & ~pop;
      push      = wrEn & ~ovf;
      level_d   = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      errSum   = {1'b0, errCnt_q} + 17'(ovf) + 17'(pairErr);
      errCnt_d = errSum[16] ? 16'hFFFF : errSum[15:0];
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wrPtr_q] <= {data_q, iLatch_q};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= WAIT_I;
         vld_q        <= 1'b0;
         ca_q         <= 1'b0;
         data_q       <= '0;
         iLatch_q     <= '0;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         level_q      <= '0;
         outVld_q     <= 1'b0;
         outData_q    <= '0;
         ovfSticky_q  <= 1'b0;
         pairSticky_q <= 1'b0;
         errCnt_q     <= '0;
      end else begin
         vld_q  <= i_data_vld;
         ca_q   <= i_data_ca;
         data_q <= i_data;

         if (!i_enable) begin
            state_q <= WAIT_I;
         end else if (vld_q) begin
            case (state_q)
               WAIT_I: begin
                  if (!ca_q) begin
                     iLatch_q <= data_q;
                     state_q  <= WAIT_Q;
                  end
               end
               WAIT_Q: begin
                  if (ca_q) begin
                     state_q <= WAIT_I;
                  end else begin
                     iLatch_q <= data_q;
                  end
               end
               default: state_q <= WAIT_I;
            endcase
         end

         if (push) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q   <= rdPtr_q + 1'b1;
            outData_q <= mem[rdPtr_q];
            outVld_q  <= 1'b1;
         end else if (outVld_q && i_dac_rdy) begin
            outVld_q <= 1'b0;
         end
         level_q <= level_d;

         if (i_clr_err) begin
            ovfSticky_q  <= 1'b0;
            pairSticky_q <= 1'b0;
            errCnt_q     <= '0;
         end else begin
            ovfSticky_q  <= ovfSticky_q | ovf;
            pairSticky_q <= pairSticky_q | pairErr;
            errCnt_q     <= errCnt_d;
         end
      end
   end

   assign o_dac_data        = outData_q;
   assign o_dac_vld         = outVld_q;
   assign o_fifo_level      = level_q;
   assign o_ovf_sticky      = ovfSticky_q;
   assign o_pair_err_sticky = pairSticky_q;
   assign o_err_cnt         = errCnt_q;

endmodule

// File: tb/tb_duc_iq_dac_packer.sv
// Bench for duc_iq_dac_packer: queue-based reference model feeding an in-order
// scoreboard, with a negedge monitor consuming words as the DAC accepts them.
module tb_duc_iq_dac_packer;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b1;
   logic            vld = 1'b0;
   logic            ca = 1'b0;
   logic [DW-1:0]   data = '0;
   logic            rdy = 1'b1;
   logic            clr = 1'b0;
   logic [2*DW-1:0] dacData;
   logic            dacVld;
   logic [AW:0]     fifoLevel;
   logic            ovfSticky;
   logic            pairSticky;
   logic [15:0]     errCnt;

   int checks = 0;
   int errors = 0;
   int popCount = 0;

   // Reference model: registered sample, pairing state, stored words, error state
   bit          mVldR, mCaR, mWaitQ, mOutValid, mOvf, mPe;
   logic [15:0] mDataR, mILatch;
   logic [31:0] mFifo[$];
   logic [31:0] sbQ[$];
   int          mErrCnt;

   duc_iq_dac_packer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_data_vld(vld), .i_data_ca(ca),
      .i_data(data), .o_dac_data(dacData), .o_dac_vld(dacVld), .i_dac_rdy(rdy),
      .o_fifo_level(fifoLevel), .o_ovf_sticky(ovfSticky), .o_pair_err_sticky(pairSticky),
      .i_clr_err(clr), .o_err_cnt(errCnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      mVldR = 0; mCaR = 0; mDataR = '0; mWaitQ = 0; mILatch = '0;
      mFifo.delete(); sbQ.delete(); mOutValid = 0;
      mErrCnt = 0; mOvf = 0; mPe = 0;
   endtask

   // One clock edge of the specified behaviour, all decisions from pre-edge state
   task automatic modelStep();
      bit pop, evt, wr, pe, ovf;
      logic [31:0] word;
      pop  = (mFifo.size() > 0) && (!mOutValid || rdy);
      evt  = en && mVldR;
      wr   = evt && mWaitQ && mCaR;
      pe   = evt && ((!mWaitQ && mCaR) || (mWaitQ && !mCaR));
      word = {mDataR, mILatch};
      ovf  = wr && (mFifo.size() == DEPTH) && !pop;
      if (mOutValid && rdy) mOutValid = 0;
      if (pop) begin
         void'(mFifo.pop_front());
         mOutValid = 1;
      end
      if (wr && !ovf) begin
         mFifo.push_back(word);
         sbQ.push_back(word);
      end
      if (clr) begin
         mErrCnt = 0; mOvf = 0; mPe = 0;
      end else begin
         mErrCnt = mErrCnt + int'(ovf) + int'(pe);
         if (mErrCnt > 65535) mErrCnt = 65535;
         mOvf = mOvf | ovf;
         mPe  = mPe | pe;
      end
      if (!en) begin
         mWaitQ = 0;
      end else if (mVldR) begin
         if (!mWaitQ && !mCaR) begin
            mILatch = mDataR;
            mWaitQ  = 1;
         end else if (mWaitQ && mCaR) begin
            mWaitQ = 0;
         end else if (mWaitQ && !mCaR) begin
            mILatch = mDataR;
         end
      end
      mVldR = vld; mCaR = ca; mDataR = data;
   endtask

   task automatic checkState();
      checkOutput("dac_vld", 32'(dacVld), 32'(mOutValid));
      checkOutput("fifo_level", 32'(fifoLevel), 32'(mFifo.size()));
      checkOutput("err_cnt", 32'(errCnt), 32'(mErrCnt));
      checkOutput("ovf_sticky", 32'(ovfSticky), 32'(mOvf));
      checkOutput("pair_sticky", 32'(pairSticky), 32'(mPe));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) modelReset();
      else modelStep();
      #1;
      checkState();
   endtask

   task automatic applyStimulus(input logic c, input logic [15:0] d);
      vld = 1'b1; ca = c; data = d;
      tick();
      vld = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic sendPair(input logic [15:0] iv, input logic [15:0] qv);
      applyStimulus(1'b0, iv);
      applyStimulus(1'b1, qv);
   endtask

   task automatic clearErr();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   // Monitor: a word presented with ready high leaves on the coming edge
   always @(negedge clk) begin
      if (rst && dacVld && rdy) begin
         popCount++;
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dac_word: got %0h expected none", dacData);
         end else begin
            checkOutput("dac_word", dacData, sbQ.pop_front());
         end
      end
   end

   initial begin
      int base;
      modelReset();
      idle(2);
      checkOutput("reset_data", dacData, 32'h0);
      checkOutput("reset_vld", 32'(dacVld), 32'h0);
      rst = 1'b1;
      idle(2);

      // Basic pairing and two-cycle latency
      rdy = 1'b1;
      applyStimulus(1'b0, 16'h1234);
      applyStimulus(1'b1, 16'hABCD);
      tick();
      checkOutput("lat_k1_vld", 32'(dacVld), 32'h0);
      tick();
      checkOutput("lat_k2_vld", 32'(dacVld), 32'h1);
      checkOutput("lat_k2_data", dacData, 32'hABCD1234);
      idle(3);
      checkOutput("basic_err", 32'(errCnt), 32'h0);

      // Repeated I replaces the latched one
      applyStimulus(1'b0, 16'h0001);
      applyStimulus(1'b0, 16'h0002);
      applyStimulus(1'b1, 16'h0003);
      idle(4);
      checkOutput("pair_sticky_dir", 32'(pairSticky), 32'h1);
      checkOutput("pair_err_cnt", 32'(errCnt), 32'h1);

      // Overflow with DAC stalled
      clearErr();
      rdy = 1'b0;
      for (int p = 1; p <= 10; p++) sendPair(16'(p), 16'(16'h100 + p));
      idle(3);
      checkOutput("ovf_level", 32'(fifoLevel), 32'd8);
      checkOutput("ovf_cnt", 32'(errCnt), 32'h1);
      checkOutput("ovf_sticky_dir", 32'(ovfSticky), 32'h1);
      checkOutput("ovf_hold", dacData, 32'h01010001);
      base = popCount;
      rdy = 1'b1;
      idle(14);
      checkOutput("ovf_drain_cnt", 32'(popCount - base), 32'd9);

      // Disable between I and Q
      clearErr();
      base = popCount;
      applyStimulus(1'b0, 16'h5555);
      tick();
      en = 1'b0;
      tick();
      applyStimulus(1'b1, 16'h6666);
      idle(2);
      en = 1'b1;
      idle(4);
      checkOutput("en_no_word", 32'(popCount - base), 32'd0);
      checkOutput("en_no_err", 32'(errCnt), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         vld  = ($urandom_range(0, 99) < 70);
         ca   = $urandom_range(0, 99) < 45 ? 1'b0 : 1'b1;
         data = 16'($urandom);
         rdy  = ($urandom_range(0, 99) < 60);
         en   = ($urandom_range(0, 99) < 95);
         clr  = ($urandom_range(0, 999) < 5);
         tick();
      end
      vld = 1'b0; en = 1'b1; clr = 1'b0; rdy = 1'b1;
      idle(16);
      checkOutput("rand_drained", 32'(sbQ.size()), 32'd0);

      // Counter saturation from a stream of unpaired Q samples
      clearErr();
      vld = 1'b1; ca = 1'b1; data = 16'h7777;
      idle(65545);
      checkOutput("sat_cnt", 32'(errCnt), 32'hFFFF);
      clr = 1'b1; vld = 1'b0;
      tick();
      clr = 1'b0;
      checkOutput("clr_cnt", 32'(errCnt), 32'h0);
      checkOutput("clr_pair_sticky", 32'(pairSticky), 32'h0);
      idle(2);
      checkOutput("clr_cnt_after", 32'(errCnt), 32'h0);

      // Asynchronous reset with words in flight
      rdy = 1'b0;
      for (int p = 0; p < 4; p++) sendPair(16'(16'h20 + p), 16'(16'h30 + p));
      idle(2);
      checkOutput("pre_rst_level", 32'(fifoLevel), 32'd3);
      rst = 1'b0;
      #1;
      checkOutput("rst_vld", 32'(dacVld), 32'h0);
      checkOutput("rst_level", 32'(fifoLevel), 32'h0);
      modelReset();
      rdy = 1'b1;
      idle(2);
      rst = 1'b1;
      tick();
      base = popCount;
      sendPair(16'hC0DE, 16'hBEEF);
      idle(5);
      checkOutput("post_rst_words", 32'(popCount - base), 32'd1);
      checkOutput("post_rst_sb", 32'(sbQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
